// File: rtl/pipeline_output_queue.sv
// rtl/pipeline_output_queue.sv - in-order output queue with backpressure, ID flush and drop counter
// Optional flush support (live bits, dead-head drain, drop counter): define OUTPUT_QUEUE_FLUSH_EN.
module pipeline_output_queue #(
  parameter int DEPTH         = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] in_address,
  input  logic [ID_WIDTH-1:0]      in_id,
  input  logic                     in_valid,
  output logic                     out_stall,
  input  logic                     in_flush,
  input  logic [ID_WIDTH-1:0]      in_flush_id,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic                     out_valid,
  input  logic                     in_stall,
  output logic [7:0]               out_drop_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [ID_WIDTH-1:0]      id_mem   [DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [PW:0]              count;
  logic                     full, nonempty, in_xfer, head_valid, pop;

  assign full      = (count == FULL_COUNT);
  assign nonempty  = (count != '0);
  assign out_stall = full;
  assign in_xfer   = in_valid && !full;

`ifdef OUTPUT_QUEUE_FLUSH_EN
  logic [DEPTH-1:0] live, live_next, kill_vec;
  logic             head_live, head_kill, in_kill;
  logic [PW:0]      kill_cnt;
  logic [PW+8:0]    drop_sum;
  logic [7:0]       drop_count;

  assign head_live  = live[rd_ptr];
  assign head_kill  = in_flush && (in_flush_id == id_mem[rd_ptr]);
  assign in_kill    = in_xfer && in_flush && (in_id == in_flush_id);
  assign head_valid = nonempty && head_live && !head_kill;
  // A dead head leaves without waiting for the consumer.
  assign pop        = (head_valid && !in_stall) || (nonempty && !head_live);

  always_comb begin
    kill_vec = '0;
    kill_cnt = (PW+1)'(in_kill);
    for (int i = 0; i < DEPTH; i++) begin
      kill_vec[i] = in_flush && live[i] && (id_mem[i] == in_flush_id);
      kill_cnt    = kill_cnt + (PW+1)'(kill_vec[i]);
    end
    drop_sum  = (PW+9)'(drop_count) + (PW+9)'(kill_cnt);
    // Popped slots lose their live bit so stale entries never count as kills.
    live_next = live & ~kill_vec;
    if (pop)     live_next[rd_ptr] = 1'b0;
    if (in_xfer) live_next[wr_ptr] = !in_kill;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live       <= '0;
      drop_count <= '0;
    end else begin
      live       <= live_next;
      drop_count <= (drop_sum > (PW+9)'(255)) ? 8'd255 : drop_sum[7:0];
    end
  end

  assign out_drop_count = drop_count;
`else
  logic unused_flush;
  assign unused_flush   = ^{in_flush, in_flush_id};
  assign head_valid     = nonempty;
  assign pop            = head_valid && !in_stall;
  assign out_drop_count = 8'd0;
`endif

  assign out_valid   = head_valid;
  assign out_address = head_valid ? addr_mem[rd_ptr] : '0;
  assign out_id      = head_valid ? id_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      addr_mem[wr_ptr] <= in_address;
      id_mem[wr_ptr]   <= in_id;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (in_xfer) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (in_xfer && !pop)      count <= count + (PW+1)'(1);
      else if (!in_xfer && pop) count <= count - (PW+1)'(1);
    end
  end
endmodule

// File: doc/pipeline_output_queue.md
# pipeline_output_queue

Buffers transactions leaving the last `pipeline_stage` and presents them to the downstream consumer in order. Provides the backpressure the pipeline samples on its `in_stall`. Applies the same ID-based flush as the pipeline stages, so a flushed transaction cannot escape after it has left the pipeline. Sits directly downstream of `pipeline`: its inputs connect to `out_address`/`out_id`/`out_valid`, and its `out_stall` drives the pipeline's `in_stall`.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries. Power of two, ≥ 2.

Ports (widths from `defines.vh`):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting low immediately clears all state.
- `in_address`  in  `ADDRESS_WIDTH`  address from the pipeline.
- `in_id`  in  `ID_WIDTH`  transaction ID from the pipeline.
- `in_valid`  in  1  input transaction present.
- `out_stall`  out  1  backpressure to the pipeline; queue cannot accept.
- `in_flush`  in  1  flush request.
- `in_flush_id`  in  `ID_WIDTH`  ID to kill.
- `out_address`  out  `ADDRESS_WIDTH`  head address.
- `out_id`  out  `ID_WIDTH`  head ID.
- `out_valid`  out  1  head transaction presented.
- `in_stall`  in  1  consumer backpressure.
- `out_drop_count`  out  8  saturating count of transactions discarded by flush.

## Operation
- Handshakes:
  - Input transfer: `in_valid && !out_stall`.
  - Output transfer: `out_valid && !in_stall`.
- Storage:
  - Circular buffer with `DEPTH` entries. Each entry holds address, ID and a `live` bit.
  - Write and read pointers are `log2(DEPTH)` bits and wrap naturally.
  - Occupancy counter is `log2(DEPTH)+1` bits.
- Enqueue: on an input transfer, write the entry at the write pointer with `live = 1`, then advance the write pointer.
- `out_stall` = (count == `DEPTH`), decoded combinationally from the registered count.
  - No pass-through when full: the queue stalls even in a cycle that dequeues.
- Head presentation:
  - `out_valid` = (count != 0) && head `live`.
  - `out_address`/`out_id` show head contents when `out_valid` = 1, and are forced to 0 otherwise.
- Dequeue:
  - A live head pops on an output transfer.
  - A dead head pops unconditionally in the cycle it reaches the head, ignoring `in_stall`, with `out_valid` = 0 that cycle.
- Flush (when `in_flush` = 1):
  - Every stored live entry whose ID == `in_flush_id` has `live` cleared at the next edge.
  - An incoming transfer in the same cycle with a matching ID is still enqueued, but with `live = 0`. This keeps the stall and occupancy behaviour independent of flush.
  - A matching head is not presented in the flush cycle: `out_valid` is gated combinationally by `!(in_flush && in_flush_id == head ID)`, and no output transfer occurs for it.
- `out_drop_count`:
  - Increments by the number of entries killed in the cycle (stored plus incoming), summed.
  - Saturates at 255 and never wraps.
- Simultaneous enqueue and dequeue in the same cycle: count unchanged, both pointers advance.

## Timing
- Reset values: `out_valid` = 0, `out_stall` = 0, `out_address` = 0, `out_id` = 0, `out_drop_count` = 0. Pointers and count are 0; all `live` bits are 0.
- Latency: a transaction accepted at edge N is visible on `out_valid` after edge N, i.e. 1 cycle minimum.
- `out_stall` rises the cycle after the `DEPTH`-th accept. It falls the cycle after the first dequeue from full.
- A dead head consumes one cycle to pop. Consecutive dead entries drain at one per cycle.
- Reset asserted mid-operation discards all contents immediately and asynchronously. No output transfer completes in that cycle.

## Configuration
- `OUTPUT_QUEUE_FLUSH_EN` defined:
  - Flush logic, `live` bits, dead-head drain and drop counter are all present, as described above.
- Undefined:
  - `in_flush`/`in_flush_id` are ignored.
  - Every entry is live; `out_valid` = (count != 0).
  - `out_drop_count` is tied to 0.

## Test plan
- Fill and stall: `DEPTH` = 4, `in_stall` = 1, push IDs 1..5 back-to-back.
  - → IDs 1–4 accepted; `out_stall` = 1 from the cycle after the 4th accept; ID 5 held.
  - Release `in_stall` → outputs in order 1, 2, 3, 4, 5.
- Wrap-around: stream 12 transactions, addresses 0x10..0x1B, with `in_stall` toggled every cycle.
  - → all 12 emerge in order, with no loss or duplication.
- Stored flush: queue holds IDs 2, 3, 2; `in_stall` = 1; flush ID 2.
  - → `out_drop_count` = 2.
  - Release `in_stall` → only ID 3 presented; 2 dead-pop cycles with `out_valid` = 0.
- Incoming flush: accept ID 7 in the same cycle as flush ID 7, queue empty.
  - → ID 7 never presented; `out_drop_count` +1.
- Saturation: 300 flushed transactions → `out_drop_count` = 255.
- Async reset: queue holding 3 entries, pull `reset` low mid-cycle.
  - → `out_valid` = 0 and `out_stall` = 0 immediately.
  - After release, an empty queue accepts a new transaction.
